rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 70 +++++++
 tb/tb_rf_write_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin EX/MEM writeback arbiter with a one-cycle write register and a pending-destination scoreboard.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [4:0]        ex_rd_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [4:0]        mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              rf_we_o,
    output logic [4:0]        rf_rd_o,
    output logic [DATA_W-1:0] rf_data_o,
    input  logic              issue_valid_i,
    input  logic [4:0]        issue_rd_i,
    output logic              issue_ready_o,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    output logic              stall_o
);
    logic              r_last_mem;
    logic [NREGS-1:0]  r_pending;
    logic [NREGS-1:0]  w_pend_nxt;
    logic              w_ex_xfer;
    logic              w_mem_xfer;
    logic              w_wr;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_data;

    assign ex_ready_o  = ex_valid_i & (~mem_valid_i | r_last_mem);
    assign mem_ready_o = mem_valid_i & (~ex_valid_i | ~r_last_mem);
    assign w_ex_xfer   = ex_valid_i & ex_ready_o;
    assign w_mem_xfer  = mem_valid_i & mem_ready_o;
    assign w_rd        = w_ex_xfer ? ex_rd_i : mem_rd_i;
    assign w_data      = w_ex_xfer ? ex_data_i : mem_data_i;
    // writes to x0 are accepted but never reach the register file
    assign w_wr        = (w_ex_xfer | w_mem_xfer) && (w_rd != 5'd0);

    // bit 0 is held at zero, so x0 always reads as not pending
    assign issue_ready_o = ~r_pending[issue_rd_i];
    assign stall_o       = r_pending[rs1_i] | r_pending[rs2_i];

    always_comb begin
        w_pend_nxt = r_pending;
        if (rf_we_o) w_pend_nxt[rf_rd_o] = 1'b0;
        if (issue_valid_i && issue_ready_o) w_pend_nxt[issue_rd_i] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rf_we_o    <= 1'b0;
            rf_rd_o    <= '0;
            rf_data_o  <= '0;
            r_pending  <= '0;
            r_last_mem <= 1'b1;
        end else begin
            rf_we_o   <= w_wr;
            rf_rd_o   <= w_wr ? w_rd : '0;
            rf_data_o <= w_wr ? w_data : '0;
            r_pending <= w_pend_nxt;
            if (w_ex_xfer | w_mem_xfer) r_last_mem <= w_mem_xfer;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table with an output scoreboard queue, plus scoreboard, collision and async-reset sequences.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rstn_i;
    logic        ex_valid_i, mem_valid_i, issue_valid_i;
    logic [4:0]  ex_rd_i, mem_rd_i, issue_rd_i, rs1_i, rs2_i;
    logic [31:0] ex_data_i, mem_data_i;
    logic        ex_ready_o, mem_ready_o, rf_we_o, issue_ready_o, stall_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        xr;
        logic        mr;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
    } out_t;

    vec_t tv[13];
    out_t q[$];

    rf_write_arbiter #(.DATA_W(32), .NREGS(32)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid_i = 0; ex_rd_i = 0; ex_data_i = 0;
        mem_valid_i = 0; mem_rd_i = 0; mem_data_i = 0;
        issue_valid_i = 0; issue_rd_i = 0; rs1_i = 0; rs2_i = 0;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        out_t e, g;
        @(negedge clk);
        ex_valid_i = v.ev; ex_rd_i = v.erd; ex_data_i = v.ed;
        mem_valid_i = v.mv; mem_rd_i = v.mrd; mem_data_i = v.md;
        #1;
        chk($sformatf("ex_ready[%0d]", i), 32'(ex_ready_o), 32'(v.xr));
        chk($sformatf("mem_ready[%0d]", i), 32'(mem_ready_o), 32'(v.mr));
        e = '0;
        if (v.ev && v.xr) e = (v.erd != 0) ? '{1'b1, v.erd, v.ed} : '0;
        else if (v.mv && v.mr) e = (v.mrd != 0) ? '{1'b1, v.mrd, v.md} : '0;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk($sformatf("rf_we[%0d]", i), 32'(rf_we_o), 32'(g.we));
        chk($sformatf("rf_rd[%0d]", i), 32'(rf_rd_o), 32'(g.rd));
        chk($sformatf("rf_data[%0d]", i), rf_data_o, g.d);
    endtask

    initial begin
        // ev erd ed  mv mrd md  ex_ready mem_ready
        tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 1, 32'hA1, 1, 2, 32'hB2, 1, 0};
        tv[2]  = '{1, 1, 32'hA1, 1, 2, 32'hB2, 0, 1};
        tv[3]  = '{1, 1, 32'hA1, 1, 2, 32'hB2, 1, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[7]  = '{0, 0, 0, 1, 0, 32'h1234, 0, 1};
        tv[8]  = '{0, 0, 0, 1, 3, 32'h33, 0, 1};
        tv[9]  = '{1, 4, 32'h44, 1, 6, 32'h66, 1, 0};
        tv[10] = '{0, 0, 0, 1, 8, 32'h88, 0, 1};
        tv[11] = '{1, 10, 32'hAA, 1, 11, 32'hBB, 1, 0};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0};

        idle_inputs();
        rstn_i = 0;
        issue_rd_i = 5'd9;
        rs1_i = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(rf_we_o), 0);
        chk("rst_rd", 32'(rf_rd_o), 0);
        chk("rst_data", rf_data_o, 0);
        chk("rst_issue_ready", 32'(issue_ready_o), 1);
        chk("rst_stall", 32'(stall_o), 0);
        ex_valid_i = 1;
        #1;
        chk("rst_ex_ready_follows", 32'(ex_ready_o), 1);
        idle_inputs();
        @(negedge clk);
        rstn_i = 1;

        for (int i = 0; i < 13; i++) run_vec(tv[i], i);

        // scoreboard: issue rd7, stall until the MEM write retires
        @(negedge clk);
        issue_valid_i = 1; issue_rd_i = 7;
        #1 chk("sb_issue7_ready", 32'(issue_ready_o), 1);
        @(negedge clk);
        issue_valid_i = 0; rs1_i = 7;
        #1;
        chk("sb_stall7", 32'(stall_o), 1);
        chk("sb_issue7_blocked", 32'(issue_ready_o), 0);
        mem_valid_i = 1; mem_rd_i = 7; mem_data_i = 32'h77;
        @(negedge clk);
        mem_valid_i = 0;
        chk("sb_we7", 32'(rf_we_o), 1);
        chk("sb_rd7", 32'(rf_rd_o), 7);
        chk("sb_stall_during_wb", 32'(stall_o), 1);
        @(negedge clk);
        chk("sb_stall_cleared", 32'(stall_o), 0);
        chk("sb_issue7_free", 32'(issue_ready_o), 1);

        // collision: issue rd9 on the edge that retires a write to rd9
        idle_inputs();
        ex_valid_i = 1; ex_rd_i = 9; ex_data_i = 32'h99;
        @(negedge clk);
        ex_valid_i = 0;
        issue_valid_i = 1; issue_rd_i = 9;
        #1;
        chk("col_we9", 32'(rf_we_o), 1);
        chk("col_rd9", 32'(rf_rd_o), 9);
        chk("col_issue9_ready", 32'(issue_ready_o), 1);
        @(negedge clk);
        issue_valid_i = 1; issue_rd_i = 0; rs1_i = 9;
        #1;
        chk("col_pending9", 32'(stall_o), 1);
        chk("col_issue0_ready", 32'(issue_ready_o), 1);
        @(negedge clk);
        issue_valid_i = 0; rs1_i = 0; rs2_i = 0;
        #1 chk("col_x0_not_pending", 32'(stall_o), 0);

        // async reset while a write is registered and r3 is pending
        idle_inputs();
        issue_valid_i = 1; issue_rd_i = 3;
        ex_valid_i = 1; ex_rd_i = 12; ex_data_i = 32'hC0C0;
        @(negedge clk);
        idle_inputs();
        rs1_i = 3;
        #1;
        chk("ar_pre_we", 32'(rf_we_o), 1);
        chk("ar_pre_stall", 32'(stall_o), 1);
        #1 rstn_i = 0;
        #1;
        chk("ar_we", 32'(rf_we_o), 0);
        chk("ar_rd", 32'(rf_rd_o), 0);
        chk("ar_data", rf_data_o, 0);
        chk("ar_stall", 32'(stall_o), 0);
        @(negedge clk);
        rstn_i = 1;
        ex_valid_i = 1; ex_rd_i = 1; mem_valid_i = 1; mem_rd_i = 2;
        #1;
        chk("ar_tie_ex_ready", 32'(ex_ready_o), 1);
        chk("ar_tie_mem_ready", 32'(mem_ready_o), 0);
        @(negedge clk);
        idle_inputs();
        chk("ar_first_edge_we", 32'(rf_we_o), 1);
        chk("ar_first_edge_rd", 32'(rf_rd_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
